fpu_mult_seq: RTL and testbench
===============================

Name: fpu_mult_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point multiplier for the FPU. It supersedes the single-cycle FP32 multiplier and adds:
- configurable exponent/mantissa widths
- radix-2^RADIX_BITS iterative shift-add significand multiply
- valid/ready handshakes on input and output
- selectable rounding mode (RNE/RTZ)
- exception flags

It sits between the FPU operand decode and the FP writeback arbiter.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa field width; significand is MAN_W+1 bits with hidden 1
RADIX_BITS, 2, multiplier bits consumed per MUL cycle; must divide-round: N = ceil((MAN_W+1)/RADIX_BITS)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operands valid
in_ready_o  out  1  block can accept operands
op_a_i  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
op_b_i  in  1+EXP_W+MAN_W  operand B
rm_i  in  1  rounding mode, captured at accept: 0=RNE, 1=RTZ
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  1+EXP_W+MAN_W  product
flags_o  out  4  {NV, OF, UF, NX}

Behaviour:
- Reset (async, rst_ni low): state=IDLE; out_valid_o=0, result_o=0, flags_o=0; all datapath registers cleared. in_ready_o=1 out of reset.
- in_ready_o = (state==IDLE), combinational from state only. No dependence on in_valid_i.
- Accept edge: in_valid_i & in_ready_o. This edge registers operands, rm_i, sign = sa^sb, and the special-case classification.

Classification (on captured operands):
- exp==0: zero. Subnormals are flushed to zero on input.
- exp all-ones, man==0: Inf.
- exp all-ones, man!=0: NaN. A NaN is signalling if man MSB==0.

Special cases (state IDLE→DONE on the accept edge; out_valid_o high 1 cycle after accept):
- Any NaN operand → canonical qNaN {0, all-ones, 1, zeros}. NV is set only if either NaN is signalling.
- Inf×zero → canonical qNaN, NV=1.
- Inf×finite-nonzero or Inf×Inf → {sign, all-ones, 0}, no flags.
- zero×finite → {sign, 0, 0}, no flags.

Normal path, state machine IDLE→MUL→RND→DONE→IDLE:
- MUL:
  - Counter runs 0..N-1.
  - Each edge adds sig_a × (next RADIX_BITS LSBs of sig_b) into a 2(MAN_W+1)-bit accumulator and shifts right.
  - Leaves for RND after exactly N edges.
- RND (1 edge):
  - Normalise: if product MSB set, take the upper bits and increment the exponent.
  - Guard = next bit; sticky = OR of the rest.
  - RNE: increment if G & (LSB | S). RTZ: never increment.
  - Mantissa carry-out after rounding increments the exponent again.
  - Exponent is computed as ea+eb-bias+norm in EXP_W+2 signed bits.
  - Overflow (e ≥ 2^EXP_W-1): RNE → ±Inf; RTZ → ±max finite. Sets OF and NX.
  - Underflow (e ≤ 0): ±zero, UF and NX set (flush-to-zero).
  - NX is set whenever G|S is nonzero.
  - State→DONE.
- Latency (normal path): out_valid_o rises N+1 edges after the accept edge. Defaults give N=12, so 13 edges.
- DONE:
  - out_valid_o=1; result_o and flags_o are held stable until out_ready_i.
  - On out_valid_o & out_ready_i: →IDLE and out_valid_o=0.
  - Next accept earliest the following cycle, so no overlap.
- in_valid_i outside IDLE is ignored, and the operand inputs are don't-care then.
- Reset asserted mid-MUL/RND/DONE: the operation is abandoned with no output. After release: IDLE, in_ready_o=1.

Test Plan:
- Normal multiply, basic latency:
  - 0x3FC00000 × 0x40000000, RNE → result 0x40400000, flags 0, out_valid_o 13 cycles after accept.
  - 1.0 × 1.0 (0x3F800000 both) → 0x3F800000, flags 0, latency 13 cycles.
- Inexact rounding: 0x3F800001 × 0x3F800001, RNE → 0x3F800002, flags NX only (0001). Same operands with RTZ → 0x3F800002, NX.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, NV (1000), 1-cycle latency.
  - 0x7FA00000 (sNaN) × 0x3F800000 → 0x7FC00000, NV.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
- Overflow/underflow:
  - 0x7F000000 × 0x7F000000, RNE → 0x7F800000, OF|NX (0101).
  - Same operands, RTZ → 0x7F7FFFFF, OF|NX.
  - 0x00800000 × 0x00800000 → 0x00000000, UF|NX (0011).
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE → result_o/flags_o stable, out_valid_o stays 1, in_ready_o stays 0, in_valid_i pulses ignored. Raise out_ready_i → IDLE next cycle.
- Reset mid-operation: drop rst_ni at MUL cycle 5 → out_valid_o=0 immediately, no result emitted. After release, in_ready_o=1 and the next accepted 0x3FC00000 × 0x40000000 yields 0x40400000.

Source files
------------

// File: rtl/fpu_mult_seq.sv
// Multi-cycle floating-point multiplier: radix-2^RADIX_BITS shift-add significand
// multiply, RNE/RTZ rounding, flush-to-zero subnormals, valid/ready on both sides.
module fpu_mult_seq #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int RADIX_BITS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [EXP_W+MAN_W:0]     op_a_i,
    input  logic [EXP_W+MAN_W:0]     op_b_i,
    input  logic                     rm_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [3:0]               flags_o
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int R     = RADIX_BITS;
    localparam int N     = (SIG_W + R - 1) / R;
    localparam int NR    = N * R;
    localparam int PW    = 2 * SIG_W;
    localparam int AW    = SIG_W + NR;
    localparam int CW    = $clog2(N + 1);
    localparam int EW    = EXP_W + 2;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SIG_W-1:0] siga_q, siga_d;
    logic [NR-1:0]    mb_q, mb_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic             sign_q, sign_d, rm_q, rm_d;
    logic [W-1:0]     res_q, res_d;
    logic [3:0]       flg_q, flg_d;

    // Operand classification, only meaningful on the accept edge
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, s_in;

    assign a_exp  = op_a_i[W-2:MAN_W];
    assign b_exp  = op_b_i[W-2:MAN_W];
    assign a_man  = op_a_i[MAN_W-1:0];
    assign b_man  = op_b_i[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) & ~(|a_man);
    assign b_inf  = (&b_exp) & ~(|b_man);
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);
    assign a_snan = a_nan & ~a_man[MAN_W-1];
    assign b_snan = b_nan & ~b_man[MAN_W-1];
    assign s_in   = op_a_i[W-1] ^ op_b_i[W-1];

    // Accumulator low R bits are always zero mid-multiply, so add-then-shift
    // collapses to shift-then-add with the partial product placed one digit lower.
    logic [SIG_W+R-1:0] pp;
    logic [AW-1:0]      acc_step;

    assign pp       = {{R{1'b0}}, siga_q} * {{SIG_W{1'b0}}, mb_q[R-1:0]};
    assign acc_step = {{R{1'b0}}, acc_q[AW-1:R]} + {pp, {(NR-R){1'b0}}};

    logic [PW-1:0]    prod, nprod;
    logic [SIG_W-1:0] sig;
    logic [SIG_W:0]   sig_r;
    logic [MAN_W-1:0] man_r;
    logic [EW-1:0]    e;
    logic             norm, guard, sticky, inc, carry, ovf, unf;

    assign prod   = acc_q[PW-1:0];
    assign norm   = prod[PW-1];
    assign nprod  = norm ? prod : {prod[PW-2:0], 1'b0};
    assign sig    = nprod[PW-1:SIG_W];
    assign guard  = nprod[SIG_W-1];
    assign sticky = |nprod[SIG_W-2:0];
    assign inc    = ~rm_q & guard & (sig[0] | sticky);
    assign sig_r  = {1'b0, sig} + (SIG_W+1)'(inc);
    assign carry  = sig_r[SIG_W];
    assign man_r  = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    assign e      = {2'b00, ea_q} + {2'b00, eb_q} - BIAS + EW'(norm) + EW'(carry);
    assign ovf    = ~e[EW-1] & (e[EW-2:0] >= EMAX[EW-2:0]);
    assign unf    = e[EW-1] | (e == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        siga_d  = siga_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        sign_d  = sign_q;
        rm_d    = rm_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sign_d  = s_in;
                    rm_d    = rm_i;
                    state_d = DONE;
                    if (a_nan | b_nan) begin
                        res_d = QNAN;
                        flg_d = {a_snan | b_snan, 3'b000};
                    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
                        res_d = QNAN;
                        flg_d = 4'b1000;
                    end else if (a_inf | b_inf) begin
                        res_d = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flg_d = 4'b0000;
                    end else if (a_zero | b_zero) begin
                        res_d = {s_in, {(W-1){1'b0}}};
                        flg_d = 4'b0000;
                    end else begin
                        siga_d  = {1'b1, a_man};
                        mb_d    = NR'({1'b1, b_man});
                        acc_d   = '0;
                        cnt_d   = '0;
                        ea_d    = a_exp;
                        eb_d    = b_exp;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d = acc_step;
                mb_d  = mb_q >> R;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = RND;
            end
            RND: begin
                state_d = DONE;
                if (ovf) begin
                    res_d = rm_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                 : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flg_d = 4'b0101;
                end else if (unf) begin
                    res_d = {sign_q, {(W-1){1'b0}}};
                    flg_d = 4'b0011;
                end else begin
                    res_d = {sign_q, e[EXP_W-1:0], man_r};
                    flg_d = {3'b000, guard | sticky};
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            siga_q  <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            sign_q  <= 1'b0;
            rm_q    <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            siga_q  <= siga_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            sign_q  <= sign_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = res_q;
    assign flags_o     = flg_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Randomised + directed bench for fpu_mult_seq (FP32 defaults) with a queue
// scoreboard fed by the driver and drained by an independent output monitor.
module tb_fpu_mult_seq;
    localparam int N     = 12;
    localparam int LAT_N = N + 1;   // edges from accept edge to out_valid, normal path
    localparam int LAT_S = 0;       // specials reach DONE on the accept edge itself

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, rm = 1'b0;
    logic        in_ready, out_valid, out_ready;
    logic        rdy_rand = 1'b1, rdy_man = 1'b1;
    bit          rand_rdy = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, result;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0, acc_edge = 0;
    bit   vld_prev = 1'b0;

    assign out_ready = rand_rdy ? rdy_rand : rdy_man;

    fpu_mult_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_a_i(op_a), .op_b_i(op_b), .rm_i(rm), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .result_o(result), .flags_o(flags)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer product, remainder-based rounding decision.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic r,
                                  output logic [31:0] res, output logic [3:0] flg, output int lat);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        int e, sh;
        longint unsigned p, q, rem, half;
        bit s  = a[31] ^ b[31];
        bit an = (ea == 255) && (a[22:0] != 0);
        bit bn = (eb == 255) && (b[22:0] != 0);
        bit ai = (ea == 255) && (a[22:0] == 0);
        bit bi = (eb == 255) && (b[22:0] == 0);
        bit az = (ea == 0);
        bit bz = (eb == 0);
        bit up;
        flg = 4'b0000;
        lat = LAT_S;
        if (an || bn) begin
            res = 32'h7FC0_0000;
            flg[3] = (an && !a[22]) || (bn && !b[22]);
        end else if ((ai && bz) || (bi && az)) begin
            res = 32'h7FC0_0000;
            flg = 4'b1000;
        end else if (ai || bi) begin
            res = {s, 8'hFF, 23'h0};
        end else if (az || bz) begin
            res = {s, 31'h0};
        end else begin
            lat = LAT_N;
            p   = (64'(a[22:0]) | (64'd1 << 23)) * (64'(b[22:0]) | (64'd1 << 23));
            sh  = (p >= (64'd1 << 47)) ? 24 : 23;
            q   = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
            up  = !r && ((rem > half) || ((rem == half) && ((q & 64'd1) != 0)));
            q   = q + 64'(up);
            e   = ea + eb - 127 + (sh - 23);
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                flg = 4'b0101;
                res = r ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
            end else if (e <= 0) begin
                flg = 4'b0011;
                res = {s, 31'h0};
            end else begin
                flg = {3'b000, rem != 0};
                res = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] m = 23'($urandom);
        case ($urandom_range(0, 15))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       begin e = 8'hFF; m = '0; end
            3:       e = 8'($urandom_range(1, 254));
            4:       e = 8'($urandom_range(190, 254));
            5:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        if ($urandom_range(0, 7) == 0) m[11:0] = '0;
        return {1'($urandom), e, m};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready_o=%0b required 1", in_ready);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r,
                        input logic [31:0] er, input logic [3:0] ef, input int el, input bit push);
        exp_t x;
        wait_idle();
        x.res = er; x.flg = ef; x.lat = el;
        if (push) sb.push_back(x);
        op_a = a; op_b = b; rm = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; rm = 1'($urandom);
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        model(a, b, r, er, ef, el);
        send(a, b, r, er, ef, el, 1'b1);
    endtask

    // Output monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) acc_edge = cyc + 1;
                if (out_valid && !vld_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: result %h with empty scoreboard", result);
                    end else begin
                        chk("latency", 32'(cyc - acc_edge), 32'(sb[0].lat));
                    end
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("result", result, x.res);
                    chk("flags", 32'(flags), 32'(x.flg));
                end
                vld_prev = out_valid;
            end else begin
                vld_prev = 1'b0;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, LAT_N, 1'b1);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, LAT_N, 1'b1);
        send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'b0001, LAT_N, 1'b1);
        send(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'b0001, LAT_N, 1'b1);
        send(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, LAT_S, 1'b1);
        send(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, LAT_S, 1'b1);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, LAT_S, 1'b1);
        send(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000, LAT_S, 1'b1);
        send(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000, LAT_S, 1'b1);
        send(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101, LAT_N, 1'b1);
        send(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101, LAT_N, 1'b1);
        send(32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011, LAT_N, 1'b1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) send_model(rnd_op(), rnd_op(), 1'($urandom));
        rdy_man  = 1'b1;
        rand_rdy = 1'b0;

        // Backpressure in DONE
        wait_idle();
        rdy_man = 1'b0;
        send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, LAT_N, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_result_held", result, 32'h40400000);
            chk("bp_flags_held", 32'(flags), 32'h0);
        end
        in_valid = 1'b0;
        rdy_man  = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Reset during MUL
        send(32'h3FC00000, 32'h40000000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, LAT_N, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
